// File: rtl/score_display_if.sv
// Score display bus: counter-side score input and board-side display outputs.
interface score_display_if;
  logic [6:0] value_i;
  logic [6:0] seg_o;
  logic [1:0] dig_sel_o;
  logic       busy_o;

  modport master (output value_i, input seg_o, dig_sel_o, busy_o);
  modport slave  (input value_i, output seg_o, dig_sel_o, busy_o);
endinterface

// File: rtl/score_display.sv
// Two-digit seven-segment driver: double-dabble BCD conversion plus digit multiplexing.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit for valid scores.
module score_display #(
  parameter int MUX_DIV = 1000
) (
  input logic           clk_i,
  input logic           rst_i,
  score_display_if.slave bus
);

  localparam int CW = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(MUX_DIV - 1);
  localparam logic [6:0] DASH = 7'h40;
  localparam logic [6:0] ZERO = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_RST = 7'h00;
`else
  localparam logic [6:0] TENS_RST = ZERO;
`endif

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state, state_d;
  logic [6:0]    last_q, last_d;
  logic [6:0]    shreg, shreg_d;
  logic [7:0]    bcd, bcd_d, adj;
  logic [2:0]    step, step_d;
  logic [6:0]    tens_q, tens_d, ones_q, ones_d;
  logic [CW-1:0] mux_cnt;
  logic [1:0]    dig_sel;
  logic [6:0]    seg;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    last_d  = last_q;
    shreg_d = shreg;
    bcd_d   = bcd;
    step_d  = step;
    tens_d  = tens_q;
    ones_d  = ones_q;
    adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    case (state)
      IDLE: begin
        if (bus.value_i != last_q) begin
          last_d  = bus.value_i;
          shreg_d = bus.value_i;
          bcd_d   = '0;
          step_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        // Adjust-then-shift over the concatenated {bcd, shreg}.
        bcd_d   = {adj[6:0], shreg[6]};
        shreg_d = {shreg[5:0], 1'b0};
        step_d  = step + 3'd1;
        if (step == 3'd6) state_d = DONE;
      end
      DONE: begin
        if (last_q > 7'd99) begin
          tens_d = DASH;
          ones_d = DASH;
        end else begin
          ones_d = seg_of(bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
          tens_d = (bcd[7:4] == 4'd0) ? 7'h00 : seg_of(bcd[7:4]);
`else
          tens_d = seg_of(bcd[7:4]);
`endif
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      last_q <= '0;
      shreg  <= '0;
      bcd    <= '0;
      step   <= '0;
      tens_q <= TENS_RST;
      ones_q <= ZERO;
    end else begin
      state  <= state_d;
      last_q <= last_d;
      shreg  <= shreg_d;
      bcd    <= bcd_d;
      step   <= step_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  // Free-running digit mux; seg reloads every edge so register updates show one edge later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mux_cnt <= '0;
      dig_sel <= 2'b01;
      seg     <= ZERO;
    end else if (mux_cnt == TC) begin
      mux_cnt <= '0;
      dig_sel <= ~dig_sel;
      seg     <= dig_sel[0] ? tens_q : ones_q;
    end else begin
      mux_cnt <= mux_cnt + CW'(1);
      seg     <= dig_sel[0] ? ones_q : tens_q;
    end
  end

  assign bus.seg_o     = seg;
  assign bus.dig_sel_o = dig_sel;
  assign bus.busy_o    = (state != IDLE);

endmodule

// File: tb/tb_score_display.sv
// Randomized self-checking bench for score_display against an arithmetic display model.
module tb_score_display;

  localparam int MD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   edges = 0;
  int   model_last = 0;

  score_display_if bus ();

  score_display #(.MUX_DIV(MD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference mux phase: edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic logic [6:0] digit_code(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction

  function automatic logic [6:0] exp_ones(input int v);
    if (v > 99) return 7'h40;
    return digit_code(v % 10);
  endfunction

  function automatic logic [6:0] exp_tens(input int v);
    if (v > 99) return 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
    if (v / 10 == 0) return 7'h00;
`endif
    return digit_code(v / 10);
  endfunction

  function automatic logic [1:0] exp_sel();
    return (((edges / MD) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Observe one full refresh period of a settled display.
  task automatic check_display(input int v);
    logic [1:0] s;
    for (int i = 0; i < 2 * MD; i++) begin
      @(negedge clk);
      s = exp_sel();
      check("dig_sel", bus.dig_sel_o, s);
      check($sformatf("seg[%0d]", v), bus.seg_o, (s == 2'b01) ? exp_ones(v) : exp_tens(v));
    end
  endtask

  task automatic apply(input int v);
    int busy_cnt;
    busy_cnt = 0;
    bus.value_i = 7'(v);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy_o);
    end
    check($sformatf("busy_len[%0d]", v), busy_cnt, (v != model_last) ? 8 : 0);
    model_last = v;
    check_display(v);
  endtask

  initial begin
    int seen7f;
    bus.value_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_seg", bus.seg_o, 7'h3F);
    check("rst_sel", bus.dig_sel_o, 2'b01);
    check("rst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    check_display(0);

    apply(42);

    for (int v = 0; v < 100; v++) apply(v);

    apply(100);
    apply(127);
    apply(55);

    for (int i = 0; i < 25; i++) apply(int'($urandom_range(0, 127)));

    // Change while busy: 37 arrives mid-conversion of 12.
    bus.value_i = 7'd12;
    @(negedge clk); check("busy_e0", bus.busy_o, 1'b1);
    @(negedge clk);
    bus.value_i = 7'd37;
    repeat (6) @(negedge clk);
    check("busy_e7", bus.busy_o, 1'b1);
    @(negedge clk); check("busy_e8", bus.busy_o, 1'b0);
    @(negedge clk); check("busy_e9", bus.busy_o, 1'b1);
    repeat (12) @(negedge clk);
    check("busy_after", bus.busy_o, 1'b0);
    model_last = 37;
    check_display(37);

    // Reset in the middle of converting 88.
    bus.value_i = 7'd88;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.value_i = 7'd0;
    #1;
    check("midrst_seg", bus.seg_o, 7'h3F);
    check("midrst_sel", bus.dig_sel_o, 2'b01);
    check("midrst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_last = 0;
    seen7f = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.seg_o == 7'h7F) seen7f++;
    end
    check("no_7f", seen7f, 0);
    check_display(0);

    apply(7);
    apply(10);
    apply(99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
